// File: rtl/time_keeper_if.sv
// Display-side bundle from the time keeper to the 7-seg segment decoder.
// fsm_state carries the current mode (0=RUN, 1=SET_HOUR, 2=SET_MIN) for observation.
interface time_keeper_if;
    logic [11:0] data_show;
    logic [2:0]  byte_status;
    logic [3:0]  segment_byte_control;
    logic        tick_1hz;
    logic [1:0]  fsm_state;

    modport master (
        output data_show,
        output byte_status,
        output segment_byte_control,
        output tick_1hz,
        output fsm_state
    );

    modport slave (
        input data_show,
        input byte_status,
        input segment_byte_control,
        input tick_1hz,
        input fsm_state
    );
endinterface

// File: rtl/time_keeper.sv
// HH:MM:SS timekeeper with two-button setting, digit blink and 8-phase scan
// sequencing for a 4-digit multiplexed 7-segment display.
module time_keeper #(
    parameter int CLK_HZ   = 10_000_000,
    parameter int SCAN_DIV = 1000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          btn_mode,
    input  logic          btn_inc,
    input  logic          show_sec,
    time_keeper_if.master disp
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_SET_HOUR = 2'd1;
    localparam logic [1:0] ST_SET_MIN  = 2'd2;

    localparam int PW = $clog2(CLK_HZ);
    localparam int BW = $clog2(CLK_HZ / 4);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_TICK  = PW'(CLK_HZ - 2);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(CLK_HZ / 4 - 1);
    localparam logic [SW-1:0] SCAN_LAST   = SW'(SCAN_DIV - 1);

    // Bit 0/1 are the synchronizer flops, bit 2 is the previous synced level.
    logic [2:0] mode_sync;
    logic [2:0] inc_sync;
    logic [1:0] show_sync;

    logic mode_press;
    logic inc_press;
    logic inc_eff;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       leave_set_min;

    logic [PW-1:0] presc;
    logic          tick_q;

    logic [5:0] sec_q;
    logic [5:0] min_q;
    logic [5:0] hour_q;

    logic [BW-1:0] blink_div;
    logic          blink_on;

    logic [SW-1:0] scan_div;
    logic [2:0]    byte_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_sync <= 3'b000;
            inc_sync  <= 3'b000;
            show_sync <= 2'b00;
        end else begin
            mode_sync <= {mode_sync[1:0], btn_mode};
            inc_sync  <= {inc_sync[1:0], btn_inc};
            show_sync <= {show_sync[0], show_sec};
        end
    end

    assign mode_press = mode_sync[1] & ~mode_sync[2];
    assign inc_press  = inc_sync[1] & ~inc_sync[2];
    // A mode press in the same cycle swallows any inc press.
    assign inc_eff    = inc_press & ~mode_press;

    always_comb begin
        state_next = state;
        if (mode_press) begin
            case (state)
                ST_RUN:      state_next = ST_SET_HOUR;
                ST_SET_HOUR: state_next = ST_SET_MIN;
                ST_SET_MIN:  state_next = ST_RUN;
                default:     state_next = ST_RUN;
            endcase
        end
    end

    assign leave_set_min = mode_press && (state == ST_SET_MIN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // tick_1hz is registered one cycle early so it is high exactly while the
    // prescaler sits at its last count; time advances on the wrap edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc  <= '0;
            tick_q <= 1'b0;
        end else begin
            if ((state != ST_RUN) || (state_next != ST_RUN)) begin
                presc <= '0;
            end else if (presc == PRESC_LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
            tick_q <= (state == ST_RUN) && (state_next == ST_RUN) && (presc == PRESC_TICK);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sec_q  <= 6'd0;
            min_q  <= 6'd0;
            hour_q <= 6'd0;
        end else if (tick_q) begin
            if (sec_q == 6'd59) begin
                sec_q <= 6'd0;
                if (min_q == 6'd59) begin
                    min_q  <= 6'd0;
                    hour_q <= (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
                end else begin
                    min_q <= min_q + 6'd1;
                end
            end else begin
                sec_q <= sec_q + 6'd1;
            end
        end else begin
            if (leave_set_min) begin
                sec_q <= 6'd0;
            end
            if (inc_eff && (state == ST_SET_HOUR)) begin
                hour_q <= (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
            end
            if (inc_eff && (state == ST_SET_MIN)) begin
                min_q <= (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            end
        end
    end

    // Any press restarts the blink period with digits visible, so the
    // user always sees the value they just changed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_div <= '0;
            blink_on  <= 1'b1;
        end else if (mode_press || inc_press) begin
            blink_div <= '0;
            blink_on  <= 1'b1;
        end else if (blink_div == BLINK_LAST) begin
            blink_div <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_div <= blink_div + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_div <= '0;
            byte_q   <= 3'd0;
        end else if (scan_div == SCAN_LAST) begin
            scan_div <= '0;
            byte_q   <= byte_q + 3'd1;
        end else begin
            scan_div <= scan_div + 1'b1;
        end
    end

    always_comb begin
        if ((state == ST_RUN) && show_sync[1]) begin
            disp.data_show = {min_q, sec_q};
        end else begin
            disp.data_show = {hour_q, min_q};
        end
    end

    always_comb begin
        if ((state == ST_RUN) || blink_on) begin
            disp.segment_byte_control = 4'b1111;
        end else if (state == ST_SET_HOUR) begin
            disp.segment_byte_control = 4'b0011;
        end else begin
            disp.segment_byte_control = 4'b1100;
        end
    end

    assign disp.byte_status = byte_q;
    assign disp.tick_1hz    = tick_q;
    assign disp.fsm_state   = state;

    a_sec_range: assert property (@(posedge clock) disable iff (reset) sec_q < 6'd60);
    a_min_range: assert property (@(posedge clock) disable iff (reset) min_q < 6'd60);
    a_hour_range: assert property (@(posedge clock) disable iff (reset) hour_q < 6'd24);
    a_state_legal: assert property (@(posedge clock) disable iff (reset) state != 2'd3);
    a_tick_in_run: assert property (@(posedge clock) disable iff (reset) tick_q |-> (state == ST_RUN));

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper at CLK_HZ=8, SCAN_DIV=2: a vector table for
// free-running count/scan plus hand sequences for setting, blink and reset.
module tb_time_keeper;

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_SET_HOUR = 2'd1;
  localparam logic [1:0] S_SET_MIN  = 2'd2;

  logic clock;
  logic reset;
  logic btn_mode;
  logic btn_inc;
  logic show_sec;

  int tests_run;
  int fails;
  int tick_cnt;

  time_keeper_if disp ();

  time_keeper #(
    .CLK_HZ  (8),
    .SCAN_DIV(2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .show_sec(show_sec),
    .disp    (disp)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int          adv;
    logic        ss;
    logic [11:0] exp_data;
    logic [2:0]  exp_byte;
    logic        exp_tick;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n clocks; returns at the falling edge after the last rising edge.
  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (disp.tick_1hz) tick_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    step(2);
    reset = 1'b0;
    tick_cnt = 0;
  endtask

  // Pins rise at a falling edge; the action lands on the 3rd rising edge.
  task automatic press(input logic m, input logic i, input int settle);
    btn_mode = m;
    btn_inc = i;
    step(3);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    step(settle);
  endtask

  task automatic press_n(input logic m, input logic i, input int n);
    for (int p = 0; p < n; p++) press(m, i, 3);
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    tick_cnt = 0;
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    show_sec = 1'b1;

    // N = rising edges since reset release; sec = N/8, byte = (N/2)%8, tick when N%8==7
    vecs[0] = '{1,   1'b1, 12'd0,  3'd0, 1'b0};
    vecs[1] = '{6,   1'b1, 12'd0,  3'd3, 1'b1};
    vecs[2] = '{1,   1'b1, 12'd1,  3'd4, 1'b0};
    vecs[3] = '{7,   1'b1, 12'd1,  3'd7, 1'b1};
    vecs[4] = '{1,   1'b1, 12'd2,  3'd0, 1'b0};
    vecs[5] = '{4,   1'b0, 12'd0,  3'd2, 1'b0};
    vecs[6] = '{4,   1'b1, 12'd3,  3'd4, 1'b0};
    vecs[7] = '{455, 1'b1, 12'd59, 3'd7, 1'b1};
    vecs[8] = '{1,   1'b1, 12'd64, 3'd0, 1'b0};

    // reset state
    do_reset();
    check("rst_data", 32'(disp.data_show), 32'd0);
    check("rst_byte", 32'(disp.byte_status), 32'd0);
    check("rst_ctrl", 32'(disp.segment_byte_control), 32'hF);
    check("rst_tick", 32'(disp.tick_1hz), 32'd0);
    check("rst_state", 32'(disp.fsm_state), 32'(S_RUN));

    // free-running count and scan
    for (int i = 0; i < 9; i++) begin
      show_sec = vecs[i].ss;
      step(vecs[i].adv);
      check($sformatf("vec%0d_data", i), 32'(disp.data_show), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_byte", i), 32'(disp.byte_status), 32'(vecs[i].exp_byte));
      check($sformatf("vec%0d_tick", i), 32'(disp.tick_1hz), 32'(vecs[i].exp_tick));
      check($sformatf("vec%0d_ctrl", i), 32'(disp.segment_byte_control), 32'hF);
    end
    check("run_tick_count", 32'(tick_cnt), 32'd60);

    // scan sequence: each phase held 2 cycles
    do_reset();
    for (int k = 0; k < 18; k++) begin
      check($sformatf("scan%0d", k), 32'(disp.byte_status), 32'((k / 2) % 8));
      step(1);
    end

    // setting with rollover, exit clears sec
    show_sec = 1'b0;
    do_reset();
    step(40);
    check("pre_set_data", 32'(disp.data_show), 32'd0);
    show_sec = 1'b1;
    press(1'b1, 1'b0, 0);
    check("set_hour_state", 32'(disp.fsm_state), 32'(S_SET_HOUR));
    check("set_hour_shows_hhmm", 32'(disp.data_show), 32'd0);
    step(3);
    btn_inc = 1'b1;
    step(10);
    btn_inc = 1'b0;
    step(3);
    check("hold_one_press", 32'(disp.data_show), 32'({6'd1, 6'd0}));
    press_n(1'b0, 1'b1, 22);
    check("hour_23", 32'(disp.data_show), 32'({6'd23, 6'd0}));
    press_n(1'b0, 1'b1, 1);
    check("hour_wrap", 32'(disp.data_show), 32'({6'd0, 6'd0}));
    press_n(1'b0, 1'b1, 23);
    check("hour_23b", 32'(disp.data_show), 32'({6'd23, 6'd0}));
    press(1'b1, 1'b0, 3);
    check("set_min_state", 32'(disp.fsm_state), 32'(S_SET_MIN));
    press_n(1'b0, 1'b1, 59);
    check("min_59", 32'(disp.data_show), 32'({6'd23, 6'd59}));
    press_n(1'b0, 1'b1, 1);
    check("min_wrap", 32'(disp.data_show), 32'({6'd23, 6'd0}));
    press_n(1'b0, 1'b1, 59);
    check("min_59b", 32'(disp.data_show), 32'({6'd23, 6'd59}));
    press(1'b1, 1'b0, 0);
    tick_cnt = 0;
    check("exit_state", 32'(disp.fsm_state), 32'(S_RUN));
    check("exit_sec_cleared", 32'(disp.data_show), 32'({6'd59, 6'd0}));
    step(7);
    check("exit_first_tick", 32'(disp.tick_1hz), 32'd1);
    check("exit_pre_inc", 32'(disp.data_show), 32'({6'd59, 6'd0}));
    step(1);
    check("exit_sec1", 32'(disp.data_show), 32'({6'd59, 6'd1}));
    step(471);
    check("exit_sec59", 32'(disp.data_show), 32'({6'd59, 6'd59}));
    step(1);
    check("midnight_mmss", 32'(disp.data_show), 32'd0);
    check("midnight_ticks", 32'(tick_cnt), 32'd60);
    show_sec = 1'b0;
    step(2);
    check("midnight_hhmm", 32'(disp.data_show), 32'd0);

    // blink in SET_HOUR, forced visible by a press
    do_reset();
    press(1'b1, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("blink_h%0d", k), 32'(disp.segment_byte_control),
            ((k / 2) % 2 == 0) ? 32'hF : 32'h3);
      step(1);
    end
    press(1'b0, 1'b1, 0);
    check("blink_press_on", 32'(disp.segment_byte_control), 32'hF);
    check("blink_press_hour", 32'(disp.data_show), 32'({6'd1, 6'd0}));
    step(1);
    check("blink_press_on2", 32'(disp.segment_byte_control), 32'hF);
    step(1);
    check("blink_press_off", 32'(disp.segment_byte_control), 32'h3);
    step(3);
    press(1'b1, 1'b0, 2);
    check("blink_min_off", 32'(disp.segment_byte_control), 32'hC);

    // inc ignored in RUN
    do_reset();
    step(3);
    press(1'b0, 1'b1, 3);
    check("run_inc_state", 32'(disp.fsm_state), 32'(S_RUN));
    check("run_inc_data", 32'(disp.data_show), 32'd0);

    // simultaneous mode+inc: mode wins; no action before 3rd edge
    do_reset();
    step(3);
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    step(2);
    check("simul_edge2_state", 32'(disp.fsm_state), 32'(S_RUN));
    step(1);
    check("simul_state", 32'(disp.fsm_state), 32'(S_SET_HOUR));
    check("simul_hour", 32'(disp.data_show), 32'd0);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    step(3);

    // async reset in SET_MIN at min=30
    do_reset();
    press(1'b1, 1'b0, 3);
    press(1'b1, 1'b0, 3);
    press_n(1'b0, 1'b1, 30);
    step(1);
    check("pre_rst_min30", 32'(disp.data_show), 32'({6'd0, 6'd30}));
    reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(disp.fsm_state), 32'(S_RUN));
    check("mid_rst_data", 32'(disp.data_show), 32'd0);
    check("mid_rst_ctrl", 32'(disp.segment_byte_control), 32'hF);
    check("mid_rst_byte", 32'(disp.byte_status), 32'd0);
    check("mid_rst_tick", 32'(disp.tick_1hz), 32'd0);
    step(2);
    reset = 1'b0;
    step(2);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
